sprite_sequencer_fsm: RTL

- Parametrised frame-sequencing controller for the VGA game datapath. Successor to the single-sprite draw/wait/erase/update controller.
- Draws the static floors/background once after start, then runs a frame loop over NUM_SPRITES sprites: load, draw, wait a programmable number of frame ticks, erase, update.
- Sits between the top-level game logic and the pixel datapath. Drives per-sprite select plus load/draw/erase/update strobes and the framebuffer write enable.

---
 rtl/sprite_seq_pkg.sv | 45 ++++
 rtl/frame_wait_counter.sv | 34 +++
 rtl/sprite_sequencer_fsm.sv | 119 +++++++++++
 3 files changed

// File: rtl/sprite_seq_pkg.sv
// Shared types for the sprite frame sequencer: FSM state encoding, the
// registered strobe bundle and small elaboration-time helpers.
package sprite_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BG     = 3'd1,
    S_LOAD   = 3'd2,
    S_DRAW   = 3'd3,
    S_WAIT   = 3'd4,
    S_ERASE  = 3'd5,
    S_UPDATE = 3'd6
  } state_t;

  typedef struct packed {
    logic drawing_bg;
    logic ld_sprite;
    logic draw_sprite;
    logic erase;
    logic update;
    logic write_en;
    logic frame_busy;
  } strobes_t;

  // Smallest sprite_sel width able to index n sprites.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic strobes_t decode_state(input state_t s);
    strobes_t o;
    o = '0;
    case (s)
      S_BG:     begin o.drawing_bg  = 1'b1; o.write_en = 1'b1; end
      S_LOAD:         o.ld_sprite   = 1'b1;
      S_DRAW:   begin o.draw_sprite = 1'b1; o.write_en = 1'b1; end
      S_ERASE:  begin o.erase       = 1'b1; o.write_en = 1'b1; end
      S_UPDATE:       o.update      = 1'b1;
      default:  ;
    endcase
    o.frame_busy = (s != S_IDLE) && (s != S_WAIT);
    return o;
  endfunction

endpackage

// File: rtl/frame_wait_counter.sv
// Counts frame ticks against a limit latched on load; terminal flags the
// tick that should end the wait (a limit of 0 or 1 ends on the first tick).
module frame_wait_counter #(
  parameter int WAIT_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [WAIT_W-1:0] wait_frames,
  input  logic              tick,
  input  logic              hold,
  output logic              terminal
);

  logic [WAIT_W-1:0] count;
  logic [WAIT_W-1:0] limit;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      limit <= '0;
    end else if (load) begin
      count <= '0;
      limit <= wait_frames;
    end else if (tick && !hold) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (limit == '0) || (count == limit - 1'b1);

endmodule

// File: rtl/sprite_sequencer_fsm.sv
// Frame sequencer: background once, then load/draw/wait/erase/update over
// NUM_SPRITES sprites. Define SPRITE_SEQ_PAUSE_EN to add the pause input.
module sprite_sequencer_fsm
  import sprite_seq_pkg::*;
#(
  parameter int NUM_SPRITES = 2,
  parameter int SEL_W       = 4,
  parameter int WAIT_W      = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              frame_tick,
  input  logic [WAIT_W-1:0] wait_frames,
  input  logic              bg_done,
  input  logic              draw_done,
  input  logic              erase_done,
`ifdef SPRITE_SEQ_PAUSE_EN
  input  logic              pause,
`endif
  output logic [SEL_W-1:0]  sprite_sel,
  output logic              drawing_bg,
  output logic              ld_sprite,
  output logic              draw_sprite,
  output logic              erase,
  output logic              update,
  output logic              writeEn,
  output logic              frame_busy
);

  localparam int               SEL_W_MIN = sel_width(NUM_SPRITES);
  localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(NUM_SPRITES - 1);

  if (SEL_W < SEL_W_MIN) begin : g_bad_sel_w
    $error("SEL_W too narrow for NUM_SPRITES");
  end

  state_t           state, state_nxt;
  logic [SEL_W-1:0] sel_nxt;
  strobes_t         strb;
  logic             wait_hold, wait_term;

`ifdef SPRITE_SEQ_PAUSE_EN
  assign wait_hold = pause;
`else
  assign wait_hold = 1'b0;
`endif

  frame_wait_counter #(.WAIT_W(WAIT_W)) u_wait (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        ((state != S_WAIT) && (state_nxt == S_WAIT)),
    .wait_frames (wait_frames),
    .tick        ((state == S_WAIT) && frame_tick),
    .hold        (wait_hold),
    .terminal    (wait_term)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sprite_sel;
    case (state)
      S_IDLE: if (start) state_nxt = S_BG;
      S_BG: if (bg_done) begin
        state_nxt = S_LOAD;
        sel_nxt   = '0;
      end
      S_LOAD: state_nxt = S_DRAW;
      S_DRAW: if (draw_done) begin
        if (sprite_sel == LAST_SEL) begin
          state_nxt = S_WAIT;
          sel_nxt   = '0;
        end else begin
          state_nxt = S_LOAD;
          sel_nxt   = sprite_sel + 1'b1;
        end
      end
      S_WAIT: if (frame_tick && wait_term && !wait_hold) state_nxt = S_ERASE;
      S_ERASE: if (erase_done) state_nxt = S_UPDATE;
      S_UPDATE: begin
        if (sprite_sel == LAST_SEL) begin
          state_nxt = S_LOAD;
          sel_nxt   = '0;
        end else begin
          state_nxt = S_ERASE;
          sel_nxt   = sprite_sel + 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        sel_nxt   = '0;
      end
    endcase
  end

  // Strobes are decoded from the next state so they register glitch-free yet
  // line up with the state they belong to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      sprite_sel <= '0;
      strb       <= '0;
    end else begin
      state      <= state_nxt;
      sprite_sel <= sel_nxt;
      strb       <= decode_state(state_nxt);
    end
  end

  assign drawing_bg  = strb.drawing_bg;
  assign ld_sprite   = strb.ld_sprite;
  assign draw_sprite = strb.draw_sprite;
  assign erase       = strb.erase;
  assign update      = strb.update;
  assign writeEn     = strb.write_en;
  assign frame_busy  = strb.frame_busy;

endmodule
